gmii_tx_framer: RTL

Parametrised GMII transmit framer and successor to the simple pass-through GMII TX stage. It accepts a byte stream with valid/ready/last framing and drives GMII TXD/TX_EN/TX_ER. It inserts preamble and SFD, pads short frames, optionally appends the FCS, enforces the inter-frame gap, and flags source underruns with TX_ER. It sits between the MAC packet source and the RGMII/GMII pad logic, on the 125 MHz transmit clock.

---
 rtl/gmii_tx_framer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD insertion, short-frame padding, inter-frame gap and TX_ER on underrun.
// Define GMII_TX_FCS_EN to compute and append the IEEE 802.3 CRC-32 FCS after the payload.
module gmii_tx_framer #(
    parameter int PREAMBLE_BYTES = 7,
    parameter int IFG_BYTES      = 12,
    parameter int MIN_PAYLOAD    = 60,
    parameter int CNT_W          = 11
) (
    input  logic       clk,
    input  logic       i_reset,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    input  logic       i_last,
    output logic       o_ready,
    output logic [7:0] o_txd,
    output logic       o_tx_en,
    output logic       o_tx_er,
    output logic       o_busy,
    output logic       o_frame_done,
    output logic       o_underrun
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_PAYLOAD,
        ST_PAD,
`ifdef GMII_TX_FCS_EN
        ST_FCS,
`endif
        ST_IFG
    } state_t;

    localparam logic [3:0] PRE_LAST = 4'(PREAMBLE_BYTES - 1);
    localparam logic [7:0] IFG_LAST = 8'(IFG_BYTES - 1);

`ifdef GMII_TX_FCS_EN
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
    // After the last data/pad byte the frame continues with the FCS, so done waits for it.
    localparam state_t ST_TAIL   = ST_FCS;
    localparam logic   TAIL_DONE = 1'b0;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in, input logic [7:0] data);
        logic [31:0] c;
        c = crc_in ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction
`else
    localparam state_t ST_TAIL   = ST_IFG;
    localparam logic   TAIL_DONE = 1'b1;
`endif

    state_t           state;
    logic [3:0]       pre_cnt;
    logic [7:0]       ifg_cnt;
    logic [CNT_W-1:0] byte_cnt;
    logic [CNT_W:0]   cnt_inc;
    logic [CNT_W-1:0] cnt_sat;
    logic             need_pad;
`ifdef GMII_TX_FCS_EN
    logic [31:0]      crc;
    logic [1:0]       fcs_idx;
    logic [31:0]      fcs_word;
`endif

    // The count after this cycle's byte decides whether more pad is required.
    assign cnt_inc  = {1'b0, byte_cnt} + (CNT_W + 1)'(1);
    assign cnt_sat  = (&byte_cnt) ? byte_cnt : cnt_inc[CNT_W-1:0];
    assign need_pad = int'(cnt_inc) < MIN_PAYLOAD;

    assign o_ready = (state == ST_PAYLOAD);
    assign o_busy  = (state != ST_IDLE);

`ifdef GMII_TX_FCS_EN
    assign fcs_word = ~crc;
`endif

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state        <= ST_IDLE;
            pre_cnt      <= '0;
            ifg_cnt      <= '0;
            byte_cnt     <= '0;
            o_txd        <= '0;
            o_tx_en      <= 1'b0;
            o_tx_er      <= 1'b0;
            o_frame_done <= 1'b0;
            o_underrun   <= 1'b0;
`ifdef GMII_TX_FCS_EN
            crc          <= CRC_INIT;
            fcs_idx      <= '0;
`endif
        end else begin
            // NOTE: every registered output and per-state counter gets a default here, so pulses
            // last exactly one cycle and each state only overrides what it drives.
            o_txd        <= '0;
            o_tx_en      <= 1'b0;
            o_tx_er      <= 1'b0;
            o_frame_done <= 1'b0;
            o_underrun   <= 1'b0;
            pre_cnt      <= '0;
            ifg_cnt      <= '0;
`ifdef GMII_TX_FCS_EN
            fcs_idx      <= '0;
`endif
            case (state)
                ST_IDLE: begin
                    byte_cnt <= '0;
                    if (i_valid) begin
                        state <= ST_PREAMBLE;
                    end
                end

                ST_PREAMBLE: begin
                    o_txd   <= 8'h55;
                    o_tx_en <= 1'b1;
                    if (pre_cnt == PRE_LAST) begin
                        state <= ST_SFD;
                    end else begin
                        pre_cnt <= pre_cnt + 4'd1;
                    end
                end

                ST_SFD: begin
                    o_txd    <= 8'hD5;
                    o_tx_en  <= 1'b1;
                    byte_cnt <= '0;
`ifdef GMII_TX_FCS_EN
                    crc      <= CRC_INIT;
`endif
                    state    <= ST_PAYLOAD;
                end

                ST_PAYLOAD: begin
                    o_tx_en <= 1'b1;
                    if (i_valid) begin
                        o_txd    <= i_data;
                        byte_cnt <= cnt_sat;
`ifdef GMII_TX_FCS_EN
                        crc      <= crc32_byte(crc, i_data);
`endif
                        if (i_last) begin
                            if (need_pad) begin
                                state <= ST_PAD;
                            end else begin
                                state        <= ST_TAIL;
                                o_frame_done <= TAIL_DONE;
                            end
                        end
                    end else begin
                        // Source starved mid-frame: the frame is knowingly corrupted with TX_ER.
                        o_tx_er    <= 1'b1;
                        o_underrun <= 1'b1;
                    end
                end

                ST_PAD: begin
                    o_tx_en  <= 1'b1;
                    byte_cnt <= cnt_sat;
`ifdef GMII_TX_FCS_EN
                    crc      <= crc32_byte(crc, 8'h00);
`endif
                    if (!need_pad) begin
                        state        <= ST_TAIL;
                        o_frame_done <= TAIL_DONE;
                    end
                end

`ifdef GMII_TX_FCS_EN
                ST_FCS: begin
                    o_txd   <= fcs_word[8*fcs_idx +: 8];
                    o_tx_en <= 1'b1;
                    if (fcs_idx == 2'd3) begin
                        state        <= ST_IFG;
                        o_frame_done <= 1'b1;
                    end else begin
                        fcs_idx <= fcs_idx + 2'd1;
                    end
                end
`endif

                ST_IFG: begin
                    if (ifg_cnt == IFG_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        ifg_cnt <= ifg_cnt + 8'd1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
